// File: rtl/bydin_pkg.sv
// bydin_pkg: shared constants and FSM state type for the deinterleaver read controller
package bydin_pkg;
  localparam int FRAME_LEN_DEF = 16128;
  localparam int RD_LAT = 4;
  localparam int IW = $clog2(RD_LAT + 1);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
endpackage

// File: rtl/bydin_byte_fifo.sv
// bydin_byte_fifo: synchronous first-word fall-through byte FIFO
//   push/din  write side, ignored when full unless a pop happens in the same cycle
//   pop/dout  read side, dout is the head byte (0 while empty)
//   empty/full/cnt  occupancy status
module bydin_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   cnt
);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic wr_en, rd_en;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign cnt = cnt_q;
  assign dout = empty ? 8'h00 : mem_q[rd_q];
  always_comb begin
    wr_en = push && (!full || pop);
    rd_en = pop && !empty;
    wr_d = wr_en ? wr_q + 1'b1 : wr_q;
    rd_d = rd_en ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q] <= din;
endmodule

// File: rtl/bydin_rd_ctrl.sv
// bydin_rd_ctrl: reads one frame per deinterleaver interrupt and streams it to SPI tx
//   bydin_int                      frame interrupt (asynchronous, synchronised here)
//   mem_rd_ena / mem_ena_in / mem_data_in   memory read port, RD_LAT cycle latency
//   tx_data / tx_valid / tx_ready  byte stream to SPI tx
//   frame_start / frame_done / busy         frame status
//   err_clr / irq_miss / ovf_err            sticky error flags and their clear
module bydin_rd_ctrl import bydin_pkg::*; #(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       bydin_int,
  output logic       mem_rd_ena,
  input  logic [7:0] mem_data_in,
  input  logic       mem_ena_in,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       frame_start,
  output logic       frame_done,
  output logic       busy,
  input  logic       err_clr,
  output logic       irq_miss,
  output logic       ovf_err
);
  localparam int CW = FIFO_AW + 2;
  localparam logic [15:0] LEN = 16'(FRAME_LEN);
  state_t state_q, state_d;
  logic sync1_q, sync2_q, sync3_q, int_evt_q, int_evt_d;
  logic [15:0] req_cnt_q, req_cnt_d, out_cnt_q, out_cnt_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic irq_miss_q, irq_miss_d, ovf_err_q, ovf_err_d;
  logic push, pop, full, empty;
  logic [FIFO_AW:0] fifo_cnt;
  assign busy = state_q != IDLE;
  assign frame_start = state_q == IDLE && int_evt_q;
  // Credits: bytes already buffered plus reads still in the memory pipe never exceed the FIFO
  assign mem_rd_ena = state_q == READ && req_cnt_q < LEN &&
                      CW'(fifo_cnt) + CW'(inflight_q) < CW'(FIFO_DEPTH);
  // Strobes arriving after an aborted frame are dropped silently while idle
  assign push = mem_ena_in && busy;
  assign tx_valid = !empty;
  assign pop = tx_valid && tx_ready;
  assign frame_done = state_q == DRAIN && pop && out_cnt_q == LEN - 16'd1;
  assign irq_miss = irq_miss_q;
  assign ovf_err = ovf_err_q;
  bydin_byte_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(push), .din(mem_data_in), .pop(pop),
    .dout(tx_data), .empty(empty), .full(full), .cnt(fifo_cnt)
  );
  always_comb begin
    int_evt_d = sync2_q && !sync3_q;
    state_d = frame_start ? READ :
              (mem_rd_ena && req_cnt_q == LEN - 16'd1) ? DRAIN :
              frame_done ? IDLE : state_q;
    req_cnt_d = frame_start ? '0 : req_cnt_q + 16'(mem_rd_ena);
    out_cnt_d = frame_start ? '0 : out_cnt_q + 16'(pop && busy);
    // A return in the same cycle as an issue cancels; a stray return never underflows
    inflight_d = inflight_q + IW'(mem_rd_ena) -
                 IW'(mem_ena_in && (inflight_q != '0 || mem_rd_ena));
    irq_miss_d = (int_evt_q && busy) || (irq_miss_q && !err_clr);
    ovf_err_d = (push && full && !pop) || (ovf_err_q && !err_clr);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      int_evt_q <= 1'b0;
      req_cnt_q <= '0;
      out_cnt_q <= '0;
      inflight_q <= '0;
      irq_miss_q <= 1'b0;
      ovf_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= bydin_int;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      int_evt_q <= int_evt_d;
      req_cnt_q <= req_cnt_d;
      out_cnt_q <= out_cnt_d;
      inflight_q <= inflight_d;
      irq_miss_q <= irq_miss_d;
      ovf_err_q <= ovf_err_d;
    end
endmodule

// File: tb/tb_bydin_rd_ctrl.sv
// tb_bydin_rd_ctrl: randomized self-checking bench with a behavioural memory and byte-stream model
module tb_bydin_rd_ctrl;
  localparam int FL = 288;
  logic clk = 1'b0, reset_n = 1'b1;
  logic bydin_int = 1'b0, tx_ready = 1'b0, err_clr = 1'b0;
  logic mem_rd_ena, mem_ena_in, tx_valid, frame_start, frame_done, busy, irq_miss, ovf_err;
  logic [7:0] mem_data_in, tx_data;
  logic bydin_int1 = 1'b0, tx_ready1 = 1'b1, err_clr1 = 1'b0;
  logic mem_rd_ena1, mem_ena_in1, tx_valid1, frame_start1, frame_done1, busy1, irq_miss1, ovf_err1;
  logic [7:0] mem_data_in1, tx_data1;
  logic frc_ena = 1'b0;
  logic [7:0] frc_data = 8'h00;
  int base0 = 0, base1 = 0, cyc = 0, checks = 0, failures = 0;
  int start_cnt = 0, done_cnt = 0, start_cyc = 0, done_cyc = 0, issued = 0, popped = 0, credit_viol = 0;
  int start1_cnt = 0, done1_cnt = 0, start1_cyc = 0, done1_cyc = 0, rd1_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] rx1_q[$];
  logic [3:0] pv0 = '0, pv1 = '0;
  int pa0 [4];
  int pa1 [4];
  int addr0 = 0, addr1 = 0;

  bydin_rd_ctrl #(.FRAME_LEN(FL)) dut (
    .clk(clk), .reset_n(reset_n), .bydin_int(bydin_int), .mem_rd_ena(mem_rd_ena),
    .mem_data_in(mem_data_in), .mem_ena_in(mem_ena_in), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .frame_start(frame_start), .frame_done(frame_done), .busy(busy),
    .err_clr(err_clr), .irq_miss(irq_miss), .ovf_err(ovf_err)
  );
  bydin_rd_ctrl #(.FRAME_LEN(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bydin_int(bydin_int1), .mem_rd_ena(mem_rd_ena1),
    .mem_data_in(mem_data_in1), .mem_ena_in(mem_ena_in1), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .frame_start(frame_start1), .frame_done(frame_done1), .busy(busy1),
    .err_clr(err_clr1), .irq_miss(irq_miss1), .ovf_err(ovf_err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mdat(input int a);
    logic [31:0] v;
    v = a;
    return v[16:9] ^ v[7:0];
  endfunction

  // Deinterleaver memory: sequential addresses from the frame base, data after 4 cycles
  always @(posedge clk) begin
    addr0 <= frame_start ? base0 : addr0 + (mem_rd_ena ? 1 : 0);
    pv0 <= {pv0[2:0], mem_rd_ena};
    pa0[0] <= addr0; pa0[1] <= pa0[0]; pa0[2] <= pa0[1]; pa0[3] <= pa0[2];
    addr1 <= frame_start1 ? base1 : addr1 + (mem_rd_ena1 ? 1 : 0);
    pv1 <= {pv1[2:0], mem_rd_ena1};
    pa1[0] <= addr1; pa1[1] <= pa1[0]; pa1[2] <= pa1[1]; pa1[3] <= pa1[2];
  end
  assign mem_ena_in = pv0[3] | frc_ena;
  assign mem_data_in = frc_ena ? frc_data : mdat(pa0[3]);
  assign mem_ena_in1 = pv1[3];
  assign mem_data_in1 = mdat(pa1[3]);

  // Stream monitors; "issued - popped" is every byte requested but not yet handed to tx
  always @(negedge clk) begin
    if (frame_start) begin
      start_cnt <= start_cnt + 1; start_cyc <= cyc; issued <= 0; popped <= 0; done_cnt <= 0;
      rx_q.delete();
    end
    if (mem_rd_ena) begin
      if (issued - popped >= 8) credit_viol <= credit_viol + 1;
      issued <= issued + 1;
    end
    if (tx_valid && tx_ready) begin
      rx_q.push_back(tx_data); popped <= popped + 1;
    end
    if (frame_done) begin
      done_cnt <= done_cnt + 1; done_cyc <= cyc;
    end
    if (frame_start1) begin
      start1_cnt <= start1_cnt + 1; start1_cyc <= cyc; rd1_cnt <= 0; done1_cnt <= 0;
      rx1_q.delete();
    end
    if (mem_rd_ena1) rd1_cnt <= rd1_cnt + 1;
    if (tx_valid1 && tx_ready1) rx1_q.push_back(tx_data1);
    if (frame_done1) begin
      done1_cnt <= done1_cnt + 1; done1_cyc <= cyc;
    end
  end

  function automatic int seq_errs(input int base);
    int e = 0;
    for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== mdat(base + i)) e++;
    return e;
  endfunction

  task automatic start_frame(input string nm);
    @(posedge clk); #1 bydin_int = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b0) begin failures++; $display("FAIL %s_start_early: frame_start=%b want 0", nm, frame_start); end
    @(posedge clk); @(negedge clk);
    checks++;
    if (frame_start !== 1'b1) begin failures++; $display("FAIL %s_start_latency: frame_start=%b want 1", nm, frame_start); end
    repeat (2) @(posedge clk); #1 bydin_int = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, input string nm);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      if (rnd) tx_ready = ($urandom_range(0, 99) < 30);
      n++;
    end
    tx_ready = 1'b1;
    checks++;
    if (done_cnt == 0) begin failures++; $display("FAIL %s_timeout: no frame_done in %0d cycles", nm, budget); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_rd_ena, tx_valid, tx_data, frame_start, frame_done, busy, irq_miss, ovf_err} !== 15'h0) begin
      failures++; $display("FAIL reset_outputs: got %h want 0", {mem_rd_ena, tx_valid, tx_data, frame_start, frame_done, busy, irq_miss, ovf_err});
    end
    checks++;
    if ({mem_rd_ena1, tx_valid1, tx_data1, frame_start1, frame_done1, busy1, irq_miss1, ovf_err1} !== 15'h0) begin
      failures++; $display("FAIL reset_outputs1: got %h want 0", {mem_rd_ena1, tx_valid1, tx_data1, frame_start1, frame_done1, busy1, irq_miss1, ovf_err1});
    end
    repeat (2) @(posedge clk); #1 reset_n = 1'b1;
    repeat (4) @(posedge clk); @(negedge clk);
    checks++;
    if ({busy, tx_valid, mem_rd_ena} !== 3'b000) begin failures++; $display("FAIL reset_idle: got %b want 000", {busy, tx_valid, mem_rd_ena}); end
  endtask

  task automatic test_full_rate();
    tx_ready = 1'b1;
    base0 = int'($urandom_range(0, 131071));
    start_frame("full");
    wait_done(1000, 1'b0, "full");
    checks++;
    if (rx_q.size() != FL) begin failures++; $display("FAIL full_count: got %0d want %0d", rx_q.size(), FL); end
    checks++;
    if (seq_errs(base0) != 0) begin failures++; $display("FAIL full_data: %0d bad bytes want 0", seq_errs(base0)); end
    checks++;
    if (done_cyc - start_cyc != FL + 5) begin failures++; $display("FAIL full_latency: got %0d want %0d", done_cyc - start_cyc, FL + 5); end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL full_done_pulses: got %0d want 1", done_cnt); end
    checks++;
    if ({busy, irq_miss, ovf_err} !== 3'b000) begin failures++; $display("FAIL full_flags: got %b want 000", {busy, irq_miss, ovf_err}); end
  endtask

  task automatic test_random_ready();
    tx_ready = 1'b0;
    base0 = int'($urandom_range(0, 131071));
    start_frame("rnd");
    wait_done(6000, 1'b1, "rnd");
    checks++;
    if (rx_q.size() != FL) begin failures++; $display("FAIL rnd_count: got %0d want %0d", rx_q.size(), FL); end
    checks++;
    if (seq_errs(base0) != 0) begin failures++; $display("FAIL rnd_data: %0d bad bytes want 0", seq_errs(base0)); end
    checks++;
    if (credit_viol != 0) begin failures++; $display("FAIL rnd_credit: %0d reads issued with 8 outstanding want 0", credit_viol); end
    checks++;
    if (ovf_err !== 1'b0) begin failures++; $display("FAIL rnd_ovf: got %b want 0", ovf_err); end
  endtask

  task automatic test_irq_miss();
    int s0;
    s0 = start_cnt;
    tx_ready = 1'b1;
    base0 = int'($urandom_range(0, 131071));
    start_frame("irq");
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, irq_miss} !== 2'b10) begin failures++; $display("FAIL irq_pre: busy,irq_miss=%b want 10", {busy, irq_miss}); end
    @(posedge clk); #1 bydin_int = 1'b1; err_clr = 1'b1;
    repeat (4) @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (irq_miss !== 1'b1) begin failures++; $display("FAIL irq_set_over_clr: got %b want 1", irq_miss); end
    repeat (2) @(posedge clk); #1 bydin_int = 1'b0;
    wait_done(1000, 1'b0, "irq");
    checks++;
    if (seq_errs(base0) != 0 || rx_q.size() != FL) begin failures++; $display("FAIL irq_data: %0d bad of %0d bytes want 0 of %0d", seq_errs(base0), rx_q.size(), FL); end
    checks++;
    if (start_cnt - s0 != 1 || done_cnt != 1) begin failures++; $display("FAIL irq_one_frame: starts=%0d dones=%0d want 1 1", start_cnt - s0, done_cnt); end
    checks++;
    if (irq_miss !== 1'b1) begin failures++; $display("FAIL irq_sticky: got %b want 1", irq_miss); end
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (irq_miss !== 1'b0) begin failures++; $display("FAIL irq_clear: got %b want 0", irq_miss); end
  endtask

  task automatic test_overflow();
    tx_ready = 1'b0;
    base0 = int'($urandom_range(0, 131071));
    start_frame("ovf");
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_rd_ena, tx_valid, tx_data} !== {2'b01, mdat(base0)}) begin
      failures++; $display("FAIL ovf_stall: rd,valid,data=%h want %h", {mem_rd_ena, tx_valid, tx_data}, {2'b01, mdat(base0)});
    end
    @(posedge clk); #1 frc_ena = 1'b1; frc_data = ~mdat(base0);
    @(posedge clk); #1 frc_ena = 1'b0;
    @(negedge clk);
    checks++;
    if ({ovf_err, tx_data} !== {1'b1, mdat(base0)}) begin
      failures++; $display("FAIL ovf_set: ovf,head=%h want %h", {ovf_err, tx_data}, {1'b1, mdat(base0)});
    end
    tx_ready = 1'b1;
    wait_done(1000, 1'b0, "ovf");
    checks++;
    if (seq_errs(base0) != 0 || rx_q.size() != FL) begin failures++; $display("FAIL ovf_data: %0d bad of %0d bytes want 0 of %0d", seq_errs(base0), rx_q.size(), FL); end
    checks++;
    if (credit_viol != 0) begin failures++; $display("FAIL ovf_credit: got %0d want 0", credit_viol); end
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (ovf_err !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b want 0", ovf_err); end
  endtask

  task automatic test_frame_len1();
    int n = 0;
    logic [7:0] got;
    base1 = int'($urandom_range(0, 131071));
    @(posedge clk); #1 bydin_int1 = 1'b1;
    while (done1_cnt == 0 && n < 60) begin
      @(posedge clk); #1;
      if (n == 5) bydin_int1 = 1'b0;
      n++;
    end
    bydin_int1 = 1'b0;
    repeat (3) @(negedge clk);
    got = rx1_q.size() > 0 ? rx1_q[0] : 8'hxx;
    checks++;
    if (done1_cnt != 1) begin failures++; $display("FAIL len1_done: got %0d want 1", done1_cnt); end
    checks++;
    if (rd1_cnt != 1) begin failures++; $display("FAIL len1_reads: got %0d want 1", rd1_cnt); end
    checks++;
    if (done1_cyc - start1_cyc != 6) begin failures++; $display("FAIL len1_latency: got %0d want 6", done1_cyc - start1_cyc); end
    checks++;
    if (rx1_q.size() != 1 || got !== mdat(base1)) begin failures++; $display("FAIL len1_data: %0d bytes first %h want 1 bytes %h", rx1_q.size(), got, mdat(base1)); end
    checks++;
    if ({busy1, ovf_err1, irq_miss1} !== 3'b000) begin failures++; $display("FAIL len1_flags: got %b want 000", {busy1, ovf_err1, irq_miss1}); end
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b1;
    base0 = int'($urandom_range(0, 131071));
    start_frame("rst");
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, mem_rd_ena} !== 2'b11) begin failures++; $display("FAIL rst_mid_read: busy,rd=%b want 11", {busy, mem_rd_ena}); end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_rd_ena, tx_valid, tx_data, frame_start, frame_done, busy, irq_miss, ovf_err} !== 15'h0) begin
      failures++; $display("FAIL rst_async: got %h want 0", {mem_rd_ena, tx_valid, tx_data, frame_start, frame_done, busy, irq_miss, ovf_err});
    end
    repeat (2) @(posedge clk); #1 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, tx_valid, ovf_err} !== 3'b000) begin failures++; $display("FAIL rst_late_strobes: got %b want 000", {busy, tx_valid, ovf_err}); end
    base0 = int'($urandom_range(0, 131071));
    start_frame("rst2");
    wait_done(1000, 1'b0, "rst2");
    checks++;
    if (seq_errs(base0) != 0 || rx_q.size() != FL) begin failures++; $display("FAIL rst_clean_frame: %0d bad of %0d bytes want 0 of %0d", seq_errs(base0), rx_q.size(), FL); end
    checks++;
    if (done_cyc - start_cyc != FL + 5) begin failures++; $display("FAIL rst_latency: got %0d want %0d", done_cyc - start_cyc, FL + 5); end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_random_ready();
    test_irq_miss();
    test_overflow();
    test_frame_len1();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
